mult_sequencer: RTL and testbench
=================================

Name: mult_sequencer

Overview:
- Control FSM for the shift-and-add multiplier datapath.
- On each cycle it drives the 3-bit register write select into the write-enable decoder: R0=000, R1=001, R2=010, R3=011, R4=100, RP0=101, RP1=110, 111=no write.
- It also drives the read-port selects and the ALU op, and produces {RP0,RP1} = R0 × R1 after DATAWIDTH iterations.
- It sits between the top-level start/done interface and the register file/ALU.

Parameters:
DATAWIDTH, 8, operand width and iteration count N
SELECTION, 3, width of register select buses
CNTWIDTH, 4, iteration counter width; must satisfy 2^CNTWIDTH > DATAWIDTH

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous, active-low reset
sStart  in  1  request a multiplication; sampled only in IDLE
sLsb  in  1  R1[0] from datapath, sampled in TEST
sReady  out  1  1 only in IDLE
sBusy  out  1  1 in every state except IDLE
sDone  out  1  one-cycle pulse in DONE
sSelWrite  out  SELECTION  register write select to decoder; 111 = none
sSelA  out  SELECTION  read port A select; in LOAD states, 000 = operand A bus, 001 = operand B bus
sSelB  out  SELECTION  read port B select
sAluOp  out  2  00 pass A, 01 add A+B (carry latched by datapath), 10 shift right (carry/shift-in to MSB, LSB to shift flag), 11 clear
sLoadExt  out  1  write data taken from the external operand bus
sIter  out  CNTWIDTH  current iteration index

Behaviour:
- Moore machine. All outputs decode from the registered state and counter only. There is no combinational path from input to output.
- Reset (reset_n=0 at a clk edge): state=IDLE, sIter=0, sSelWrite=111, sSelA=000, sSelB=000, sAluOp=00, sLoadExt=0, sReady=1, sBusy=0, sDone=0.
- Reset mid-operation wins over everything: the next cycle is IDLE with reset outputs, and no further register write is issued.
- Outputs in any state not listed below: sSelWrite=111, sSelA=000, sSelB=000, sAluOp=00, sLoadExt=0.
- IDLE: if sStart=1, go to LOAD_A and clear sIter; else stay in IDLE.
- LOAD_A: sSelWrite=000, sLoadExt=1, sSelA=000. Next state LOAD_B.
- LOAD_B: sSelWrite=001, sLoadExt=1, sSelA=001. Next state CLR_H.
- CLR_H: sSelWrite=101, sAluOp=11. Next state CLR_L.
- CLR_L: sSelWrite=110, sAluOp=11. Next state TEST.
- TEST: sSelWrite=111. Next state ADD if sLsb=1, else SHIFT_H.
- ADD: sSelWrite=101, sSelA=101, sSelB=000, sAluOp=01. Next state SHIFT_H.
- SHIFT_H: sSelWrite=101, sSelA=101, sAluOp=10. Carry shifts into the MSB. Next state SHIFT_L.
- SHIFT_L: sSelWrite=110, sSelA=110, sAluOp=10. Next state SHIFT_M.
- SHIFT_M: sSelWrite=001, sSelA=001, sAluOp=10.
  - If sIter==DATAWIDTH-1, go to DONE.
  - Else increment sIter and go to TEST.
- DONE: sDone=1, sSelWrite=111, sBusy=1. Next state IDLE unconditionally.
- sStart while busy (including in DONE) is ignored. If sStart is still high in IDLE, a new operation starts.
- Only one register is written per cycle. R2, R3 and R4 are never selected for write.
- sIter never exceeds DATAWIDTH-1 and wraps to 0 only on start.
- Latency: start accepted at edge E0.
  - LOAD_A occupies cycle 1.
  - DONE occupies cycle 5+4N+k, where k is the number of 1 bits sampled in TEST.
  - For N=8, DONE falls in cycles 37 to 45.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with sStart=1 -> sReady=1, sSelWrite=111, sDone=0, sIter=0. The first start is accepted only after reset_n=1.
- Operands A=0x03, B=0x00 (sLsb driven by a datapath model) -> no ADD states, sDone in cycle 37, {RP0,RP1}=0x0000, no write select 010/011/100 ever issued.
- Operands A=0xFF, B=0xFF -> 8 ADD states, sDone in cycle 45, product 0xFE01. Exactly one write select per non-TEST busy cycle.
- Operands A=0x0C, B=0x05 -> ADD in iterations 0 and 2 only, sDone in cycle 39, product 0x003C.
- Mid-operation: pulse sStart during iteration 3 -> ignored. Assert reset_n=0 in an ADD cycle -> next cycle IDLE, sSelWrite=111, sBusy=0.
- Back-to-back: hold sStart=1 continuously -> DONE, then IDLE for exactly 1 cycle, then LOAD_A. sDone pulses exactly once per operation.

Source files
------------

// File: rtl/mult_sequencer_if.sv
// Control bus between the multiplier sequencer and the start/done logic and datapath.
// The master side is the sequencer; the slave side is the datapath/top level.
interface mult_sequencer_if #(
  parameter int SELECTION = 3,
  parameter int CNTWIDTH  = 4
);
  logic                 sStart;
  logic                 sLsb;
  logic                 sReady;
  logic                 sBusy;
  logic                 sDone;
  logic [SELECTION-1:0] sSelWrite;
  logic [SELECTION-1:0] sSelA;
  logic [SELECTION-1:0] sSelB;
  logic [1:0]           sAluOp;
  logic                 sLoadExt;
  logic [CNTWIDTH-1:0]  sIter;

  modport master (
    input  sStart, sLsb,
    output sReady, sBusy, sDone, sSelWrite, sSelA, sSelB, sAluOp, sLoadExt, sIter
  );

  modport slave (
    output sStart, sLsb,
    input  sReady, sBusy, sDone, sSelWrite, sSelA, sSelB, sAluOp, sLoadExt, sIter
  );
endinterface

// File: rtl/mult_sequencer.sv
// Moore control FSM for a shift-and-add multiplier.
// The operands are loaded into R0 (multiplicand) and R1 (multiplier). The product
// registers {RP0,RP1} are cleared. Then, for each of DATAWIDTH iterations, the FSM
// tests R1[0], optionally adds R0 into RP0, and shifts RP0 -> RP1 -> R1 right by one.
// CNTWIDTH must be wide enough to hold DATAWIDTH-1 (2**CNTWIDTH > DATAWIDTH).
module mult_sequencer #(
  parameter int DATAWIDTH = 8,
  parameter int SELECTION = 3,
  parameter int CNTWIDTH  = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  mult_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CLR_H,
    S_CLR_L,
    S_TEST,
    S_ADD,
    S_SHIFT_H,
    S_SHIFT_L,
    S_SHIFT_M,
    S_DONE
  } state_t;

  // Register-file select codes; SEL_NONE suppresses the write.
  localparam logic [SELECTION-1:0] SEL_R0   = SELECTION'(0);
  localparam logic [SELECTION-1:0] SEL_R1   = SELECTION'(1);
  localparam logic [SELECTION-1:0] SEL_RP0  = SELECTION'(5);
  localparam logic [SELECTION-1:0] SEL_RP1  = SELECTION'(6);
  localparam logic [SELECTION-1:0] SEL_NONE = SELECTION'(7);

  localparam logic [1:0] ALU_PASS  = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_SHIFT = 2'b10;
  localparam logic [1:0] ALU_CLEAR = 2'b11;

  localparam logic [CNTWIDTH-1:0] LAST_ITER = CNTWIDTH'(DATAWIDTH - 1);

  state_t              state_q, state_d;
  logic [CNTWIDTH-1:0] iter_q, iter_d;

  // State and iteration counter registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state and counter update; start is only honoured in IDLE.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable unassigned (no latch).
    state_d = state_q;
    iter_d  = iter_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.sStart) begin
          state_d = S_LOAD_A;
          iter_d  = '0;
        end
      end
      S_LOAD_A:  state_d = S_LOAD_B;
      S_LOAD_B:  state_d = S_CLR_H;
      S_CLR_H:   state_d = S_CLR_L;
      S_CLR_L:   state_d = S_TEST;
      S_TEST:    state_d = bus.sLsb ? S_ADD : S_SHIFT_H;
      S_ADD:     state_d = S_SHIFT_H;
      S_SHIFT_H: state_d = S_SHIFT_L;
      S_SHIFT_L: state_d = S_SHIFT_M;
      S_SHIFT_M: begin
        if (iter_q == LAST_ITER) begin
          state_d = S_DONE;
        end else begin
          iter_d  = iter_q + 1'b1;
          state_d = S_TEST;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the registered state only.
  always_comb begin
    bus.sReady    = 1'b0;
    bus.sBusy     = 1'b1;
    bus.sDone     = 1'b0;
    bus.sSelWrite = SEL_NONE;
    bus.sSelA     = SEL_R0;
    bus.sSelB     = SEL_R0;
    bus.sAluOp    = ALU_PASS;
    bus.sLoadExt  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.sReady = 1'b1;
        bus.sBusy  = 1'b0;
      end
      S_LOAD_A: begin
        bus.sSelWrite = SEL_R0;
        bus.sSelA     = SEL_R0;
        bus.sLoadExt  = 1'b1;
      end
      S_LOAD_B: begin
        bus.sSelWrite = SEL_R1;
        bus.sSelA     = SEL_R1;
        bus.sLoadExt  = 1'b1;
      end
      S_CLR_H: begin
        bus.sSelWrite = SEL_RP0;
        bus.sAluOp    = ALU_CLEAR;
      end
      S_CLR_L: begin
        bus.sSelWrite = SEL_RP1;
        bus.sAluOp    = ALU_CLEAR;
      end
      S_ADD: begin
        bus.sSelWrite = SEL_RP0;
        bus.sSelA     = SEL_RP0;
        bus.sSelB     = SEL_R0;
        bus.sAluOp    = ALU_ADD;
      end
      S_SHIFT_H: begin
        bus.sSelWrite = SEL_RP0;
        bus.sSelA     = SEL_RP0;
        bus.sAluOp    = ALU_SHIFT;
      end
      S_SHIFT_L: begin
        bus.sSelWrite = SEL_RP1;
        bus.sSelA     = SEL_RP1;
        bus.sAluOp    = ALU_SHIFT;
      end
      S_SHIFT_M: begin
        bus.sSelWrite = SEL_R1;
        bus.sSelA     = SEL_R1;
        bus.sAluOp    = ALU_SHIFT;
      end
      S_DONE: begin
        bus.sDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.sIter = iter_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer. A small register-file/ALU model closes
// the sLsb loop. Expected results come from plain arithmetic:
//   product    = A*B
//   DONE cycle = 5 + 4N + popcount(B)
//   ADD iterations = the set bits of B
module tb_mult_sequencer;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mult_sequencer_if #(.SELECTION(3), .CNTWIDTH(4)) sif ();

  mult_sequencer #(.DATAWIDTH(N), .SELECTION(3), .CNTWIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif.master)
  );

  int total = 0;
  int bad   = 0;

  // Datapath model: register file R0..RP1 plus add carry and shift flag.
  logic [7:0] a_bus = 8'h00;
  logic [7:0] b_bus = 8'h00;
  logic [7:0] regs [0:7];
  logic       carry = 1'b0;
  logic       flag  = 1'b0;

  assign sif.sLsb = regs[1][0];

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
  end

  // Commit the write of the current cycle mid-cycle, from the outputs held in that cycle.
  always @(negedge clk) begin
    logic [7:0] opa, opb, res;
    logic [8:0] sum;
    opa = sif.sLoadExt ? ((sif.sSelA == 3'd0) ? a_bus : b_bus) : regs[sif.sSelA];
    opb = regs[sif.sSelB];
    res = opa;
    case (sif.sAluOp)
      2'b01: begin
        sum   = {1'b0, opa} + {1'b0, opb};
        res   = sum[7:0];
        carry = sum[8];
      end
      2'b10: begin
        if (sif.sSelA == 3'd5) begin
          res   = {carry, opa[7:1]};
          carry = 1'b0;
        end else begin
          res = {flag, opa[7:1]};
        end
        flag = opa[0];
      end
      2'b11: begin
        res   = 8'h00;
        carry = 1'b0;
      end
      default: ;
    endcase
    if (sif.sSelWrite != 3'b111) regs[sif.sSelWrite] = res;
  end

  // Observations from the most recent run_op.
  int          r_done_cyc;
  int          r_n_done;
  logic [15:0] r_prod;
  logic [7:0]  r_add_mask;
  int          r_illegal;
  int          r_idle_writes;
  bit          r_load_ok;
  bit          r_post_ready;
  bit          r_aborted;
  bit          r_abort_ok;

  // Run one operation from IDLE, recording what the sequencer did each cycle.
  // pulse_iter >= 0 pulses sStart in that iteration's TEST cycle.
  // abort_iter >= 0 asserts reset in that iteration's ADD cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int pulse_iter, input int abort_iter);
    bit pulsed = 0;
    r_done_cyc = 0; r_n_done = 0; r_prod = 16'hxxxx; r_add_mask = 8'h00;
    r_illegal = 0; r_idle_writes = 0; r_post_ready = 0;
    r_aborted = 0; r_abort_ok = 0;
    @(negedge clk);
    a_bus = a; b_bus = b; sif.sStart = 1'b1;
    @(negedge clk);
    sif.sStart = 1'b0;
    r_load_ok = (sif.sSelWrite == 3'b000) && sif.sLoadExt && (sif.sSelA == 3'b000) && sif.sBusy;
    for (int cyc = 1; cyc < 100; cyc++) begin
      if (sif.sSelWrite inside {3'b010, 3'b011, 3'b100}) r_illegal++;
      if (sif.sBusy && !sif.sDone && sif.sSelWrite == 3'b111) r_idle_writes++;
      if (sif.sAluOp == 2'b01 && sif.sIter < 4'd8) r_add_mask[sif.sIter[2:0]] = 1'b1;
      if (sif.sDone) begin
        r_n_done++;
        if (r_done_cyc == 0) r_done_cyc = cyc;
        r_prod = {regs[5], regs[6]};
      end else if (r_done_cyc != 0) begin
        r_post_ready = sif.sReady;
        break;
      end
      if (abort_iter >= 0 && sif.sAluOp == 2'b01 && int'(sif.sIter) == abort_iter) begin
        reset_n = 1'b0;
        @(negedge clk);
        r_aborted  = 1;
        r_abort_ok = sif.sReady && !sif.sBusy && (sif.sSelWrite == 3'b111) && (sif.sIter == 4'd0);
        reset_n = 1'b1;
        @(negedge clk);
        r_abort_ok = r_abort_ok && sif.sReady && (sif.sSelWrite == 3'b111);
        break;
      end
      if (pulse_iter >= 0 && !pulsed && int'(sif.sIter) == pulse_iter &&
          sif.sBusy && !sif.sDone && sif.sSelWrite == 3'b111) begin
        sif.sStart = 1'b1;
        pulsed = 1;
      end else begin
        sif.sStart = 1'b0;
      end
      @(negedge clk);
    end
    sif.sStart = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sif.sStart = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (sif.sReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", sif.sReady); end
    total++; if (sif.sBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", sif.sBusy); end
    total++; if (sif.sSelWrite !== 3'b111) begin bad++; $display("FAIL reset_selwrite got=%b want=111", sif.sSelWrite); end
    total++; if (sif.sDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", sif.sDone); end
    total++; if (sif.sIter !== 4'd0) begin bad++; $display("FAIL reset_iter got=%0d want=0", sif.sIter); end
    total++; if ({sif.sSelA, sif.sSelB, sif.sAluOp, sif.sLoadExt} !== 9'b0)
      begin bad++; $display("FAIL reset_ctrl got=%b want=0", {sif.sSelA, sif.sSelB, sif.sAluOp, sif.sLoadExt}); end
    sif.sStart = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (sif.sReady !== 1'b1) begin bad++; $display("FAIL reset_no_start got_ready=%b want=1", sif.sReady); end
  endtask

  task automatic test_zero();
    run_op(8'h03, 8'h00, -1, -1);
    total++; if (!r_load_ok) begin bad++; $display("FAIL zero_load_a got=0 want=1"); end
    total++; if (r_done_cyc !== 37) begin bad++; $display("FAIL zero_done_cycle got=%0d want=37", r_done_cyc); end
    total++; if (r_prod !== 16'h0000) begin bad++; $display("FAIL zero_product got=%h want=0000", r_prod); end
    total++; if (r_add_mask !== 8'h00) begin bad++; $display("FAIL zero_adds got=%b want=00000000", r_add_mask); end
    total++; if (r_illegal !== 0) begin bad++; $display("FAIL zero_illegal_sel got=%0d want=0", r_illegal); end
    total++; if (r_post_ready !== 1'b1) begin bad++; $display("FAIL zero_post_idle got=%b want=1", r_post_ready); end
  endtask

  task automatic test_full();
    run_op(8'hFF, 8'hFF, -1, -1);
    total++; if (r_done_cyc !== 45) begin bad++; $display("FAIL full_done_cycle got=%0d want=45", r_done_cyc); end
    total++; if (r_prod !== 16'hFE01) begin bad++; $display("FAIL full_product got=%h want=fe01", r_prod); end
    total++; if (r_add_mask !== 8'hFF) begin bad++; $display("FAIL full_adds got=%b want=11111111", r_add_mask); end
    total++; if (r_idle_writes !== N) begin bad++; $display("FAIL full_nowrite_cycles got=%0d want=%0d", r_idle_writes, N); end
    total++; if (r_n_done !== 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", r_n_done); end
  endtask

  task automatic test_sparse();
    run_op(8'h0C, 8'h05, -1, -1);
    total++; if (r_done_cyc !== 39) begin bad++; $display("FAIL sparse_done_cycle got=%0d want=39", r_done_cyc); end
    total++; if (r_prod !== 16'h003C) begin bad++; $display("FAIL sparse_product got=%h want=003c", r_prod); end
    total++; if (r_add_mask !== 8'h05) begin bad++; $display("FAIL sparse_adds got=%b want=00000101", r_add_mask); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [7:0] a, b;
      int exp_cyc;
      logic [15:0] exp_prod;
      a = 8'($urandom);
      b = 8'($urandom);
      exp_prod = 16'(a) * 16'(b);
      exp_cyc  = 5 + 4 * N + $countones(b);
      run_op(a, b, -1, -1);
      total++; if (r_done_cyc !== exp_cyc) begin bad++; $display("FAIL rand_done_cycle a=%h b=%h got=%0d want=%0d", a, b, r_done_cyc, exp_cyc); end
      total++; if (r_prod !== exp_prod) begin bad++; $display("FAIL rand_product a=%h b=%h got=%h want=%h", a, b, r_prod, exp_prod); end
      total++; if (r_add_mask !== b) begin bad++; $display("FAIL rand_adds a=%h b=%h got=%b want=%b", a, b, r_add_mask, b); end
      total++; if (r_illegal !== 0) begin bad++; $display("FAIL rand_illegal_sel got=%0d want=0", r_illegal); end
    end
  endtask

  task automatic test_mid_op();
    run_op(8'hFF, 8'hFF, 3, -1);
    total++; if (r_done_cyc !== 45) begin bad++; $display("FAIL midstart_done_cycle got=%0d want=45", r_done_cyc); end
    total++; if (r_prod !== 16'hFE01) begin bad++; $display("FAIL midstart_product got=%h want=fe01", r_prod); end
    total++; if (r_n_done !== 1) begin bad++; $display("FAIL midstart_done_pulses got=%0d want=1", r_n_done); end
    run_op(8'hA5, 8'hFF, -1, 2);
    total++; if (!r_aborted) begin bad++; $display("FAIL abort_reached got=0 want=1"); end
    total++; if (!r_abort_ok) begin bad++; $display("FAIL abort_idle got=0 want=1"); end
    total++; if (r_done_cyc !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", r_done_cyc); end
    run_op(8'h11, 8'h0F, -1, -1);
    total++; if (r_prod !== 16'h00FF) begin bad++; $display("FAIL abort_recover_product got=%h want=00ff", r_prod); end
  endtask

  task automatic test_back_to_back();
    bit ready_log [0:99];
    bit load_log  [0:99];
    int done_at [0:3];
    int dones = 0;
    bit drained = 0;
    @(negedge clk);
    a_bus = 8'h0C; b_bus = 8'h05; sif.sStart = 1'b1;
    for (int cyc = 1; cyc <= 85; cyc++) begin
      @(negedge clk);
      ready_log[cyc] = sif.sReady;
      load_log[cyc]  = (sif.sSelWrite == 3'b000) && sif.sLoadExt;
      if (sif.sDone) begin
        if (dones < 4) done_at[dones] = cyc;
        dones++;
        if (dones == 2) r_prod = {regs[5], regs[6]};
      end
    end
    sif.sStart = 1'b0;
    total++; if (dones !== 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=2", dones); end
    if (dones >= 2) begin
      total++; if (done_at[0] !== 39) begin bad++; $display("FAIL b2b_first_done got=%0d want=39", done_at[0]); end
      total++; if (done_at[1] !== 79) begin bad++; $display("FAIL b2b_second_done got=%0d want=79", done_at[1]); end
      total++; if (r_prod !== 16'h003C) begin bad++; $display("FAIL b2b_product got=%h want=003c", r_prod); end
    end
    total++; if (ready_log[40] !== 1'b1 || ready_log[41] !== 1'b0)
      begin bad++; $display("FAIL b2b_idle_one_cycle got=%b%b want=10", ready_log[40], ready_log[41]); end
    total++; if (load_log[41] !== 1'b1) begin bad++; $display("FAIL b2b_restart_load_a got=%b want=1", load_log[41]); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sif.sReady) begin drained = 1; break; end
    end
    total++; if (!drained) begin bad++; $display("FAIL b2b_drain_timeout got=busy want=idle"); end
  endtask

  initial begin
    sif.sStart = 1'b0;
    test_reset();
    test_zero();
    test_full();
    test_sparse();
    test_random();
    test_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
